// File: rtl/data_unit_gen.sv
// data_unit_gen: register file, PC/SP/status registers, operand muxing and a REQ/ACK memory FSM.
// Define STACK_GUARD_EN to hold SP at its limits and flag SUNF/SOVF instead of wrapping.
module data_unit_gen #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 8,
   parameter int                NREGS    = 8,
   parameter logic [ADDR_W-1:0] SP_INIT  = {ADDR_W{1'b1}},
   parameter logic [ADDR_W-1:0] SP_FLOOR = {ADDR_W{1'b0}}
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [2:0]        PC_CTRL,
   input  logic [2:0]        SP_CTRL,
   input  logic [2:0]        ST_CTRL,
   input  logic [1:0]        BUS_SEL,
   input  logic              WRITE_INSTREG,
   input  logic              WRITE_REGS,
   input  logic              WRITE_MEMADDR,
   input  logic              USE_IMMEDIATE,
   input  logic              USE_DISPLACEMENT,
   input  logic              MEM_START,
   input  logic              MEM_WE,
   output logic [ADDR_W-1:0] CODE_ADDR,
   input  logic [15:0]       CODE_DATA,
   output logic              MEM_REQ,
   output logic              MEM_WE_O,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   input  logic              MEM_ACK,
   output logic              MEM_DONE,
   output logic              BUSY,
   output logic [DATA_W-1:0] ALU_A,
   output logic [DATA_W-1:0] ALU_B,
   input  logic [DATA_W-1:0] ALU_R,
   input  logic [7:0]        ALU_ST,
   output logic [4:0]        OPCODE,
   output logic [2:0]        STATUS_SEL,
   output logic [7:0]        STATUS
);

   localparam int SW = $clog2(NREGS);
   localparam int XW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   r_sp;
   logic [15:0]         r_instreg;
   logic [DATA_W-1:0]   r_regs [NREGS];
   logic [ADDR_W-1:0]   r_memaddr;
   logic [DATA_W-1:0]   r_mdr;
   logic [7:0]          r_stat;
   logic                r_mem_req;
   logic                r_mem_done;
   logic                r_busy;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;

   logic [SW-1:0]       w_sel_a;
   logic [SW-1:0]       w_sel_b;
   logic [2:0]          w_st_sel;
   logic [DATA_W-1:0]   w_bus;
   logic [XW-1:0]       w_bus_x;
   logic [ADDR_W-1:0]   w_bus_addr;
   logic [ADDR_W-1:0]   w_pc_next;
   logic [ADDR_W-1:0]   w_sp_next;
   logic                w_sunf;
   logic                w_sovf;
   logic [7:0]          w_stat_next;
   logic                w_start_acc;
   logic                w_ack_acc;

   assign w_sel_a     = r_instreg[8 +: SW];
   assign w_sel_b     = r_instreg[0 +: SW];
   assign w_st_sel    = r_instreg[10:8];
   assign w_start_acc = (r_state == S_IDLE) && MEM_START;
   assign w_ack_acc   = (r_state == S_REQ) && MEM_ACK;

   // Internal bus source select; SP and PC are zero-extended to the data width
   always_comb begin
      w_bus = ALU_R;
      case (BUS_SEL)
         2'b00:   w_bus = ALU_R;
         2'b01:   w_bus = r_mdr;
         2'b10:   w_bus = DATA_W'(XW'(r_sp));
         2'b11:   w_bus = DATA_W'(XW'(r_pc));
         default: w_bus = ALU_R;
      endcase
      w_bus_x    = XW'(w_bus);
      w_bus_addr = ADDR_W'(w_bus_x);
   end

   // Program counter next value, CLR over INC over WR
   always_comb begin
      w_pc_next = r_pc;
      if (PC_CTRL[2]) begin
         w_pc_next = {ADDR_W{1'b0}};
      end else if (PC_CTRL[1]) begin
         w_pc_next = r_pc + ADDR_W'(1'b1);
      end else if (PC_CTRL[0]) begin
         w_pc_next = w_bus_addr;
      end else begin
         w_pc_next = r_pc;
      end
   end

   // Stack pointer next value, PRESET over INC over DEC, with optional limit guard
   always_comb begin
      w_sp_next = r_sp;
      w_sunf    = 1'b0;
      w_sovf    = 1'b0;
      if (SP_CTRL[2]) begin
         w_sp_next = SP_INIT;
      end else if (SP_CTRL[1]) begin
`ifdef STACK_GUARD_EN
         if (r_sp == SP_INIT) begin
            w_sunf = 1'b1;
         end else begin
            w_sp_next = r_sp + ADDR_W'(1'b1);
         end
`else
         w_sp_next = r_sp + ADDR_W'(1'b1);
`endif
      end else if (SP_CTRL[0]) begin
`ifdef STACK_GUARD_EN
         if (r_sp == SP_FLOOR) begin
            w_sovf = 1'b1;
         end else begin
            w_sp_next = r_sp - ADDR_W'(1'b1);
         end
`else
         w_sp_next = r_sp - ADDR_W'(1'b1);
`endif
      end else begin
         w_sp_next = r_sp;
      end
   end

   // Status next value; guard flags are ORed last so they win over WR/CLR_BIT
   always_comb begin
      w_stat_next = r_stat;
      if (ST_CTRL[2]) begin
         w_stat_next = ALU_ST;
      end else if (ST_CTRL[1]) begin
         w_stat_next[w_st_sel] = 1'b0;
      end else if (ST_CTRL[0]) begin
         w_stat_next[w_st_sel] = 1'b1;
      end else begin
         w_stat_next = r_stat;
      end
      w_stat_next = w_stat_next | {1'b0, w_sunf, w_sovf, 5'b00000};
   end

   // Memory handshake next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (MEM_START) w_state_next = S_REQ;
            else           w_state_next = S_IDLE;
         end
         S_REQ: begin
            if (MEM_ACK) w_state_next = S_DONE;
            else         w_state_next = S_REQ;
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // FSM state and its registered handshake outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_done <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_mem_req  <= (w_state_next == S_REQ);
         r_mem_done <= (w_state_next == S_DONE);
         r_busy     <= (w_state_next != S_IDLE);
      end
   end

   // Transaction latch and read-data capture
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_mem_addr  <= {ADDR_W{1'b0}};
         r_mem_wdata <= {DATA_W{1'b0}};
         r_mem_we    <= 1'b0;
         r_mdr       <= {DATA_W{1'b0}};
      end else begin
         if (w_start_acc) begin
            r_mem_addr  <= r_memaddr;
            r_mem_wdata <= w_bus;
            r_mem_we    <= MEM_WE;
         end
         if (w_ack_acc && !r_mem_we) begin
            r_mdr <= MEM_RDATA;
         end
      end
   end

   // Architectural registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pc      <= {ADDR_W{1'b0}};
         r_sp      <= SP_INIT;
         r_instreg <= 16'h0000;
         r_memaddr <= {ADDR_W{1'b0}};
         r_stat    <= 8'h00;
      end else begin
         r_pc   <= w_pc_next;
         r_sp   <= w_sp_next;
         r_stat <= w_stat_next;
         if (WRITE_INSTREG) r_instreg <= CODE_DATA;
         if (WRITE_MEMADDR) r_memaddr <= w_bus_addr;
      end
   end

   // General-purpose register file
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= {DATA_W{1'b0}};
      end else if (WRITE_REGS) begin
         r_regs[w_sel_a] <= w_bus;
      end
   end

   assign ALU_A      = USE_DISPLACEMENT ? {{(DATA_W-5){r_instreg[7]}}, r_instreg[7:3]} : r_regs[w_sel_a];
   assign ALU_B      = USE_IMMEDIATE ? DATA_W'(r_instreg[7:0]) : r_regs[w_sel_b];
   assign CODE_ADDR  = r_pc;
   assign MEM_REQ    = r_mem_req;
   assign MEM_DONE   = r_mem_done;
   assign BUSY       = r_busy;
   assign MEM_WE_O   = r_mem_we;
   assign MEM_ADDR   = r_mem_addr;
   assign MEM_WDATA  = r_mem_wdata;
   assign OPCODE     = r_instreg[15:11];
   assign STATUS_SEL = r_instreg[10:8];
   assign STATUS     = r_stat;

endmodule
